alu_flags_reg: RTL and testbench
================================

ALU_FLAGS_REG -- requirements
Module: alu_flags_reg

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port res_valid  input  1  ALU result offered.
REQ-004 SHALL have port res_ready  output  1  block can accept a result.
REQ-005 SHALL have port result  input  8  ALU result byte.
REQ-006 SHALL have port carry_in  input  1  ALU carry-out.
REQ-007 SHALL have port ovf_in  input  1  ALU signed overflow.
REQ-008 SHALL have port we_mask  input  4  per-flag update enable {Z,N,C,V}, sampled with result.
REQ-009 SHALL have port cond_sel  input  3  branch condition select.
REQ-010 SHALL have port result_q  output  8  last committed result.
REQ-011 SHALL have port flags  output  4  {Z,N,C,V} architectural flags.
REQ-012 SHALL have port flags_valid  output  1  one-cycle commit pulse.
REQ-013 SHALL have port cond_true  output  1  selected condition evaluated on flags.
REQ-014 SHALL have ports save, restore  input  1 each  shadow control, present only with FLAGS_SHADOW_EN.

Function
REQ-015 SHALL implement FSM states IDLE and EVAL; res_ready = 1 only in IDLE.
REQ-016 SHALL, on res_valid & res_ready at an edge, latch result, carry_in, ovf_in, we_mask into stage registers and go IDLE->EVAL.
REQ-017 SHALL in EVAL compute Z = (staged result == 8'h00), N = staged result[7], C = staged carry, V = staged ovf.
REQ-018 SHALL at the EVAL edge write each flag only where its we_mask bit is 1, load result_q, pulse flags_valid for exactly one cycle, return to IDLE.
REQ-019 SHALL give latency 2 edges from accept to flags visible; max throughput one result per 2 cycles.
REQ-020 SHALL still load result_q and pulse flags_valid when we_mask = 4'b0000, flags unchanged.
REQ-021 SHALL ignore res_valid in EVAL; source holds data until res_ready.
REQ-022 SHALL drive cond_true combinationally from registered flags: 000 always 1; 001 Z; 010 !Z; 011 C; 100 !C; 101 N; 110 V; 111 N^V (signed less-than).

Reset
REQ-023 SHALL on rst=1 at an edge set state IDLE, flags 4'b0000, result_q 8'h00, flags_valid 0, stage registers 0, shadow 4'b0000.
REQ-024 SHALL abandon an in-flight EVAL on reset with no flag write and no flags_valid pulse.
REQ-025 SHALL give rst priority over every other input in the same cycle.

Configuration
REQ-026 SHALL, with macro FLAGS_SHADOW_EN defined, add a 4-bit shadow register and ports save/restore.
REQ-027 SHALL with FLAGS_SHADOW_EN: save in IDLE copies flags->shadow; restore in IDLE copies shadow->flags; both together -> restore wins, shadow unchanged; both ignored in EVAL.
REQ-028 SHALL, with FLAGS_SHADOW_EN, allow restore and a handshake accept in the same IDLE cycle; restore applies, the following EVAL commit then overwrites per we_mask.
REQ-029 SHALL, without FLAGS_SHADOW_EN, omit shadow register and save/restore ports entirely; all other behaviour identical.

Verification
REQ-030 SHALL check: result=8'h00, carry=1, ovf=0, we_mask=4'b1111 -> 2 edges later flags=4'b1010, result_q=8'h00, flags_valid one cycle, cond_sel=001 -> cond_true=1.
REQ-031 SHALL check: result=8'h80, ovf=1, mask=1111 -> flags=4'b0101; cond_sel=111 -> cond_true=0; cond_sel=101 -> 1.
REQ-032 SHALL check: flags=1010 then result=8'h55, mask=4'b0100 -> flags=4'b1010 unchanged except N=0, result_q=8'h55; second res_valid held during EVAL accepted only after return to IDLE.
REQ-033 SHALL check: accept result 8'h00, assert rst in EVAL cycle -> flags=0000, result_q=00, no flags_valid, res_ready=1 next cycle.
REQ-034 SHALL check (FLAGS_SHADOW_EN): flags=1010, save; commit 8'h80 mask 1111 carry 0 -> 0100; restore -> flags=1010; save+restore together -> shadow unchanged.

Source files
------------

// File: rtl/alu_flags_reg.sv
// alu_flags_reg: two-stage ALU flag register with a valid/ready result intake,
// per-flag write enables and a combinational branch-condition evaluator.
// Optional feature macro: FLAGS_SHADOW_EN adds a 4-bit shadow copy of the
// flags with save/restore controls. If the macro is undefined, the shadow
// register and its ports are absent.
module alu_flags_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [7:0] result,
  input  logic       carry_in,
  input  logic       ovf_in,
  input  logic [3:0] we_mask,
`ifdef FLAGS_SHADOW_EN
  input  logic       save,
  input  logic       restore,
`endif
  input  logic [2:0] cond_sel,
  output logic [7:0] result_q,
  output logic [3:0] flags,
  output logic       flags_valid,
  output logic       cond_true
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EVAL = 1'b1;

  logic [0:0] state;
  logic       accept;

  logic [7:0] res_p0;
  logic       carry_p0;
  logic       ovf_p0;
  logic [3:0] mask_p0;
  logic [3:0] eval_flags_p0;

  logic       restore_now;
  logic [3:0] shadow;

  // Candidate flags {Z,N,C,V} derived from a staged result.
  function automatic logic [3:0] derive_flags(input logic [7:0] r,
                                              input logic       c,
                                              input logic       v);
    return {(r == 8'h00), r[7], c, v};
  endfunction

  // Branch condition over {Z,N,C,V}; 111 is signed less-than (N xor V).
  function automatic logic cond_eval(input logic [2:0] sel,
                                     input logic [3:0] f);
    logic res;
    res = 1'b1;
    case (sel)
      3'b000: res = 1'b1;
      3'b001: res = f[3];
      3'b010: res = ~f[3];
      3'b011: res = f[1];
      3'b100: res = ~f[1];
      3'b101: res = f[2];
      3'b110: res = f[0];
      3'b111: res = f[2] ^ f[0];
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  assign res_ready     = (state == IDLE);
  assign accept        = res_valid & res_ready;
  assign eval_flags_p0 = derive_flags(res_p0, carry_p0, ovf_p0);
  assign cond_true     = cond_eval(cond_sel, flags);

`ifdef FLAGS_SHADOW_EN
  assign restore_now = (state == IDLE) & restore;

  // Shadow copy: save only in IDLE, and restore has priority over save.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= 4'b0000;
    end else if ((state == IDLE) && save && !restore) begin
      shadow <= flags;
    end
  end
`else
  assign restore_now = 1'b0;
  assign shadow      = 4'b0000;
`endif

  // Control: IDLE accepts a result, EVAL commits it and pulses flags_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      flags_valid <= 1'b0;
    end else begin
      flags_valid <= 1'b0;
      case (state)
        IDLE: if (accept) state <= EVAL;
        EVAL: begin
          state       <= IDLE;
          flags_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: capture the offered result on handshake ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res_p0   <= 8'h00;
      carry_p0 <= 1'b0;
      ovf_p0   <= 1'b0;
      mask_p0  <= 4'b0000;
    end else if (accept) begin
      res_p0   <= result;
      carry_p0 <= carry_in;
      ovf_p0   <= ovf_in;
      mask_p0  <= we_mask;
    end
  end

  // ---- stage p1: commit result and masked flags from EVAL ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= 8'h00;
    end else if (state == EVAL) begin
      result_q <= res_p0;
    end
  end

  // Architectural flags: EVAL commit merges per mask; IDLE restore reloads shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= 4'b0000;
    end else if (state == EVAL) begin
      flags <= (flags & ~mask_p0) | (eval_flags_p0 & mask_p0);
    end else if (restore_now) begin
      flags <= shadow;
    end
  end

endmodule

// File: tb/tb_alu_flags_reg.sv
// Bench for alu_flags_reg: vector table, directed multi-cycle sequences and
// randomized transactions against a behavioural flag model.
module tb_alu_flags_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry_in;
  logic       ovf_in;
  logic [3:0] we_mask;
  logic [2:0] cond_sel;
  logic [7:0] result_q;
  logic [3:0] flags;
  logic       flags_valid;
  logic       cond_true;
`ifdef FLAGS_SHADOW_EN
  logic       save;
  logic       restore;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [3:0] m_flags;
  logic [7:0] m_res;
  logic [3:0] m_shadow;

  alu_flags_reg dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .carry_in(carry_in), .ovf_in(ovf_in), .we_mask(we_mask),
`ifdef FLAGS_SHADOW_EN
    .save(save), .restore(restore),
`endif
    .cond_sel(cond_sel), .result_q(result_q), .flags(flags),
    .flags_valid(flags_valid), .cond_true(cond_true)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       v;
    logic [3:0] m;
    logic [3:0] ef;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Flags after a commit: each enabled flag takes its newly derived value.
  function automatic logic [3:0] ref_commit(input logic [3:0] old, input logic [7:0] r,
                                            input logic c, input logic v, input logic [3:0] m);
    logic [3:0] cand;
    logic [3:0] nf;
    int sr;
    sr = (r > 8'd127) ? int'(r) - 256 : int'(r);
    cand[3] = (sr == 0);
    cand[2] = (sr < 0);
    cand[1] = c;
    cand[0] = v;
    for (int i = 0; i < 4; i++) nf[i] = m[i] ? cand[i] : old[i];
    return nf;
  endfunction

  function automatic logic ref_cond(input int sel, input logic [3:0] f);
    bit z, n, c, v;
    z = f[3]; n = f[2]; c = f[1]; v = f[0];
    case (sel)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return n;
      6: return v;
      default: return n != v;
    endcase
  endfunction

  task automatic check_all_conds(input string name);
    for (int s = 0; s < 8; s++) begin
      cond_sel = 3'(s);
      #1;
      chk(name, {31'd0, cond_true}, {31'd0, ref_cond(s, m_flags)});
    end
  endtask

  // Full handshake transaction from IDLE through commit and pulse end.
  task automatic do_txn(input logic [7:0] r, input logic c, input logic v, input logic [3:0] m);
    int n;
    n = 0;
    while (!res_ready && n < 10) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, res_ready}, 32'd1);
    res_valid = 1'b1; result = r; carry_in = c; ovf_in = v; we_mask = m;
    tick();
    res_valid = 1'b0;
    chk("eval_ready", {31'd0, res_ready}, 32'd0);
    chk("eval_no_pulse", {31'd0, flags_valid}, 32'd0);
    chk("eval_flags_hold", {28'd0, flags}, {28'd0, m_flags});
    tick();
    m_flags = ref_commit(m_flags, r, c, v, m);
    m_res   = r;
    chk("commit_flags", {28'd0, flags}, {28'd0, m_flags});
    chk("commit_result", {24'd0, result_q}, {24'd0, m_res});
    chk("commit_pulse", {31'd0, flags_valid}, 32'd1);
    chk("commit_ready", {31'd0, res_ready}, 32'd1);
    tick();
    chk("pulse_end", {31'd0, flags_valid}, 32'd0);
  endtask

`ifdef FLAGS_SHADOW_EN
  task automatic pulse_sr(input logic s, input logic r);
    save = s; restore = r;
    tick();
    save = 1'b0; restore = 1'b0;
    if (r) m_flags = m_shadow;
    else if (s) m_shadow = m_flags;
  endtask
`endif

  initial begin
    tbl[0] = '{r: 8'h00, c: 1'b1, v: 1'b0, m: 4'b1111, ef: 4'b1010};
    tbl[1] = '{r: 8'h80, c: 1'b0, v: 1'b1, m: 4'b1111, ef: 4'b0101};
    tbl[2] = '{r: 8'h55, c: 1'b0, v: 1'b0, m: 4'b0100, ef: 4'b0001};
    tbl[3] = '{r: 8'h00, c: 1'b1, v: 1'b1, m: 4'b0000, ef: 4'b0001};
    tbl[4] = '{r: 8'h7F, c: 1'b1, v: 1'b0, m: 4'b0010, ef: 4'b0011};
    tbl[5] = '{r: 8'h00, c: 1'b0, v: 1'b0, m: 4'b1000, ef: 4'b1011};
    tbl[6] = '{r: 8'hFF, c: 1'b0, v: 1'b1, m: 4'b1110, ef: 4'b0101};

    rst = 1'b1; res_valid = 1'b0; result = 8'h00; carry_in = 1'b0; ovf_in = 1'b0;
    we_mask = 4'b0000; cond_sel = 3'b000;
`ifdef FLAGS_SHADOW_EN
    save = 1'b0; restore = 1'b0;
`endif
    m_flags = 4'b0000; m_res = 8'h00; m_shadow = 4'b0000;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_result", {24'd0, result_q}, 32'd0);
    chk("rst_pulse", {31'd0, flags_valid}, 32'd0);
    chk("rst_ready", {31'd0, res_ready}, 32'd1);
    check_all_conds("rst_cond");

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      do_txn(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].m);
      chk("tbl_flags", {28'd0, flags}, {28'd0, tbl[i].ef});
      check_all_conds("tbl_cond");
    end

    // Result held during EVAL is accepted only after returning to IDLE
    do_txn(8'h00, 1'b1, 1'b0, 4'b1111);
    res_valid = 1'b1; result = 8'h55; carry_in = 1'b0; ovf_in = 1'b0; we_mask = 4'b0100;
    tick();
    result = 8'h33; we_mask = 4'b1111;
    tick();
    chk("hold_flags1", {28'd0, flags}, 32'hA);
    chk("hold_result1", {24'd0, result_q}, 32'h55);
    chk("hold_pulse1", {31'd0, flags_valid}, 32'd1);
    chk("hold_ready1", {31'd0, res_ready}, 32'd1);
    tick();
    res_valid = 1'b0;
    chk("hold_accept2", {31'd0, res_ready}, 32'd0);
    chk("hold_result_keep", {24'd0, result_q}, 32'h55);
    tick();
    chk("hold_flags2", {28'd0, flags}, 32'h0);
    chk("hold_result2", {24'd0, result_q}, 32'h33);
    chk("hold_pulse2", {31'd0, flags_valid}, 32'd1);
    tick();
    chk("hold_pulse_end", {31'd0, flags_valid}, 32'd0);
    m_flags = 4'b0000; m_res = 8'h33;

`ifdef FLAGS_SHADOW_EN
    // Shadow save / restore
    do_txn(8'h00, 1'b1, 1'b0, 4'b1111);
    pulse_sr(1'b1, 1'b0);
    do_txn(8'h80, 1'b0, 1'b0, 4'b1111);
    chk("sh_commit", {28'd0, flags}, 32'h4);
    pulse_sr(1'b0, 1'b1);
    chk("sh_restore", {28'd0, flags}, 32'hA);
    do_txn(8'h80, 1'b0, 1'b0, 4'b1111);
    pulse_sr(1'b1, 1'b1);
    chk("sh_both", {28'd0, flags}, 32'hA);
    do_txn(8'h01, 1'b1, 1'b1, 4'b1111);
    pulse_sr(1'b0, 1'b1);
    chk("sh_unchanged", {28'd0, flags}, 32'hA);
    // Restore with accept in the same cycle; save during EVAL is ignored
    do_txn(8'h01, 1'b1, 1'b1, 4'b1111);
    res_valid = 1'b1; result = 8'h01; carry_in = 1'b0; ovf_in = 1'b0; we_mask = 4'b0001;
    restore = 1'b1;
    tick();
    res_valid = 1'b0; restore = 1'b0; save = 1'b1;
    chk("sh_acc_restore", {28'd0, flags}, 32'hA);
    tick();
    save = 1'b0;
    m_flags = ref_commit(4'b1010, 8'h01, 1'b0, 1'b0, 4'b0001);
    m_res = 8'h01;
    chk("sh_acc_commit", {28'd0, flags}, {28'd0, m_flags});
    chk("sh_acc_pulse", {31'd0, flags_valid}, 32'd1);
    tick();
    do_txn(8'h80, 1'b1, 1'b1, 4'b1111);
    pulse_sr(1'b0, 1'b1);
    chk("sh_eval_save_ign", {28'd0, flags}, 32'hA);
`endif

    // Reset during EVAL abandons the commit
    do_txn(8'h80, 1'b1, 1'b1, 4'b1111);
    res_valid = 1'b1; result = 8'h00; carry_in = 1'b1; ovf_in = 1'b0; we_mask = 4'b1111;
    tick();
    res_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    m_flags = 4'b0000; m_res = 8'h00; m_shadow = 4'b0000;
    chk("rstev_flags", {28'd0, flags}, 32'd0);
    chk("rstev_result", {24'd0, result_q}, 32'd0);
    chk("rstev_pulse", {31'd0, flags_valid}, 32'd0);
    chk("rstev_ready", {31'd0, res_ready}, 32'd1);
    tick();
    chk("rstev_pulse2", {31'd0, flags_valid}, 32'd0);
    chk("rstev_flags2", {28'd0, flags}, 32'd0);

    // Reset wins over a simultaneous handshake
    do_txn(8'h80, 1'b1, 1'b1, 4'b1111);
    res_valid = 1'b1; rst = 1'b1;
    tick();
    res_valid = 1'b0; rst = 1'b0;
    m_flags = 4'b0000; m_res = 8'h00; m_shadow = 4'b0000;
    chk("rstpri_ready", {31'd0, res_ready}, 32'd1);
    chk("rstpri_flags", {28'd0, flags}, 32'd0);
    tick();
    chk("rstpri_pulse", {31'd0, flags_valid}, 32'd0);
`ifdef FLAGS_SHADOW_EN
    pulse_sr(1'b0, 1'b1);
    chk("rst_shadow", {28'd0, flags}, 32'd0);
`endif

    // Randomized transactions
    for (int k = 0; k < 150; k++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      do_txn(8'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      cond_sel = 3'($urandom);
      #1;
      chk("rand_cond", {31'd0, cond_true}, {31'd0, ref_cond(int'(cond_sel), m_flags)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
